// File: rtl/stack_pkg.sv
// Shared encodings for the CPU register-stack controller.
package stack_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_POP   = 2'b01,
    OP_PEEK  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/stack_storage.sv
// DEPTH x DATA_WIDTH register bank: one synchronous write port, one
// combinational read port, synchronous clear to zero.
module stack_storage #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // each entry loads on its own decoded write strobe
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset)
        mem[i] <= '0;
      else if (we && waddr == AW'(i))
        mem[i] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_controller.sv
// LIFO register-stack sequencer: owns the stack pointer, serves
// PUSH/POP/PEEK/CLEAR over valid/ready and returns one response per command.
module stack_controller
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH+1)
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic                  in_cmd_valid,
  input  logic [1:0]            in_cmd_op,
  input  logic [DATA_WIDTH-1:0] in_cmd_data,
  output logic                  ot_cmd_ready,
  output logic                  ot_rsp_valid,
  output logic [DATA_WIDTH-1:0] ot_rsp_data,
  output logic                  ot_rsp_err,
  output logic [CNT_WIDTH-1:0]  ot_count,
  output logic                  ot_full,
  output logic                  ot_empty,
  input  logic                  in_err_clear,
  output logic                  ot_err_sticky
);

  localparam int AW = $clog2(DEPTH);

  state_e                state;
  logic [CNT_WIDTH-1:0]  count;
  logic [AW-1:0]         sweep_idx;
  logic                  accept, is_full, is_empty;
  op_e                   op;

  logic                  st_we;
  logic [AW-1:0]         st_waddr, st_raddr;
  logic [DATA_WIDTH-1:0] st_wdata, st_rdata;

  assign op       = op_e'(in_cmd_op);
  assign is_full  = (count == CNT_WIDTH'(DEPTH));
  assign is_empty = (count == '0);
  // ready drops with reset itself, not one edge later
  assign ot_cmd_ready = (state == ST_IDLE) && !in_reset;
  assign accept       = in_cmd_valid && ot_cmd_ready;

  assign ot_count = count;
  assign ot_full  = is_full;
  assign ot_empty = is_empty;

  // top of stack sits one below the pointer
  assign st_raddr = AW'(count - 1'b1);

  // write port mux: the clear sweep owns the port while it runs
  always_comb begin
    st_we    = 1'b0;
    st_waddr = AW'(count);
    st_wdata = in_cmd_data;
    if (state == ST_CLEAR) begin
      st_we    = 1'b1;
      st_waddr = sweep_idx;
      st_wdata = '0;
    end else if (accept && op == OP_PUSH && !is_full) begin
      st_we = 1'b1;
    end
  end

  stack_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_storage (
    .clk   (in_clk),
    .reset (in_reset),
    .we    (st_we),
    .waddr (st_waddr),
    .wdata (st_wdata),
    .raddr (st_raddr),
    .rdata (st_rdata)
  );

  // FSM, stack pointer, sweep index and registered response
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state         <= ST_IDLE;
      count         <= '0;
      sweep_idx     <= '0;
      ot_rsp_valid  <= 1'b0;
      ot_rsp_data   <= '0;
      ot_rsp_err    <= 1'b0;
      ot_err_sticky <= 1'b0;
    end else begin
      ot_rsp_valid <= 1'b0;
      if (ot_rsp_valid && ot_rsp_err) ot_err_sticky <= 1'b1;
      else if (in_err_clear)          ot_err_sticky <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            unique case (op)
              OP_PUSH: begin
                ot_rsp_valid <= 1'b1;
                ot_rsp_data  <= in_cmd_data;
                ot_rsp_err   <= is_full;
                if (!is_full) count <= count + 1'b1;
              end
              OP_POP, OP_PEEK: begin
                ot_rsp_valid <= 1'b1;
                ot_rsp_data  <= is_empty ? '0 : st_rdata;
                ot_rsp_err   <= is_empty;
                if (!is_empty && op == OP_POP) count <= count - 1'b1;
              end
              OP_CLEAR: begin
                count     <= '0;
                sweep_idx <= '0;
                state     <= ST_CLEAR;
              end
            endcase
          end
        end
        ST_CLEAR: begin
          sweep_idx <= sweep_idx + 1'b1;
          if (sweep_idx == AW'(DEPTH-1)) begin
            state        <= ST_IDLE;
            ot_rsp_valid <= 1'b1;
            ot_rsp_data  <= '0;
            ot_rsp_err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/stack_controller.md
Name: stack_controller

Overview:
- Sequences a LIFO bank of DEPTH data registers, the register stack of the CPU, and owns the stack pointer.
- Accepts PUSH/POP/PEEK/CLEAR commands from the instruction sequencer over a valid/ready handshake.
- Returns one response per command and reports occupancy and errors.
- Replaces direct register writes by the sequencer; the storage lives inside this block.

Parameters:
- DATA_WIDTH, 16, width of each stack entry.
- DEPTH, 8, number of entries, >= 2.
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- in_clk  input  1  clock, all state updates on rising edge.
- in_reset  input  1  synchronous, active-high reset.
- in_cmd_valid  input  1  command present.
- in_cmd_op  input  2  00 PUSH, 01 POP, 10 PEEK, 11 CLEAR.
- in_cmd_data  input  DATA_WIDTH  push operand, ignored for other ops.
- ot_cmd_ready  output  1  controller can accept a command this cycle.
- ot_rsp_valid  output  1  one-cycle response pulse.
- ot_rsp_data  output  DATA_WIDTH  response payload.
- ot_rsp_err  output  1  response is an error, qualified by ot_rsp_valid.
- ot_count  output  CNT_WIDTH  current occupancy, 0..DEPTH.
- ot_full  output  1  ot_count == DEPTH.
- ot_empty  output  1  ot_count == 0.
- in_err_clear  input  1  clears ot_err_sticky.
- ot_err_sticky  output  1  set by any error response.

Behaviour:
- Reset (in_reset=1 at an edge):
  - All entries = 0, count = 0, FSM = ST_IDLE.
  - ot_rsp_valid = 0, ot_rsp_data = 0, ot_rsp_err = 0, ot_err_sticky = 0.
  - ot_cmd_ready is 0 while in_reset is high, and 1 in the first cycle after release.
  - Reset overrides any command or sweep in progress.
- Accept rule: a command is accepted on an edge where in_cmd_valid && ot_cmd_ready. Without ready, the command is not consumed; the requester must hold it.
- FSM states:
  - ST_IDLE: ot_cmd_ready = 1.
  - ST_CLEAR: ot_cmd_ready = 0; sweep index runs 0..DEPTH-1.
  - ST_IDLE -> ST_CLEAR on accepted CLEAR. ST_CLEAR -> ST_IDLE the cycle after index DEPTH-1 is written.
- Response timing: registered. ot_rsp_valid pulses high for exactly 1 cycle, the cycle after acceptance, for PUSH/POP/PEEK. For CLEAR it pulses the cycle after the sweep completes.
- PUSH, not full: entry[count] <= in_cmd_data, count+1, rsp_data = in_cmd_data, rsp_err = 0.
- PUSH, full: no storage or count change, rsp_data = in_cmd_data, rsp_err = 1.
- POP, not empty: rsp_data = entry[count-1] (value before the op), count-1. The vacated entry is not cleared.
- POP or PEEK, empty: no change, rsp_data = 0, rsp_err = 1.
- PEEK, not empty: rsp_data = entry[count-1], count unchanged.
- CLEAR:
  - count <= 0 at acceptance, so ot_empty = 1 from the next cycle.
  - Then writes 0 to entry[i], one entry per cycle, for i = 0..DEPTH-1.
  - Total busy = DEPTH cycles; rsp_data = 0, rsp_err = 0.
- ot_full, ot_empty and ot_count are derived from the registered count. They reflect an accepted op in the cycle after acceptance.
- ot_err_sticky: set on any cycle with ot_rsp_valid && ot_rsp_err; cleared by in_err_clear. Set wins if both occur in the same cycle.
- Back-to-back: a new command may be accepted every cycle in ST_IDLE. Each sees the state left by the previous one; PUSH then POP returns the pushed value.
- in_cmd_data is X-tolerant when op != PUSH.

Decomposition:
- Package stack_pkg:
  - Op encodings OP_PUSH, OP_POP, OP_PEEK, OP_CLEAR.
  - FSM state constants ST_IDLE, ST_CLEAR.
  - Default DATA_WIDTH.
- One sub-module, stack_storage: the DEPTH x DATA_WIDTH register array with a single synchronous write port (we, waddr, wdata), an asynchronous read port (raddr, rdata), and reset-to-zero.
- stack_controller holds the FSM, count, sweep index and response registers.

Test Plan (all with DEPTH=8):
- Reset then idle -> ot_cmd_ready=1, ot_count=0, ot_empty=1, ot_full=0, ot_rsp_valid=0.
- PUSH 16'hABCD, PUSH 16'h1234, then POP, POP back-to-back -> responses ABCD, 1234, 1234, ABCD with err=0; count sequence 1,2,1,0.
- Push 8 values 16'h0001..16'h0008 -> ot_full=1. Then PUSH 16'hCDEF -> rsp_err=1, count stays 8, ot_err_sticky=1. PEEK -> 16'h0008.
- POP on empty -> rsp_valid=1, rsp_err=1, rsp_data=0. Same cycle pulse in_err_clear -> sticky stays 1; next-cycle in_err_clear -> sticky=0.
- Push 3 values, CLEAR -> ready low exactly 8 cycles, single rsp_valid on the 9th cycle after acceptance with err=0, count=0. A PEEK held valid during the sweep is accepted only once ready returns, and responds with err=1.
- in_reset asserted mid-CLEAR sweep -> next cycle all outputs at reset values. After release, PUSH 16'h5678 then PEEK -> 16'h5678.
